// File: rtl/registrador_pkg.sv
// Shared types and constants for the serial transmit/receive register pair.
package registrador_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} tx_state_t;

    localparam logic LINE_IDLE = 1'b0;

endpackage

// File: rtl/registrador_piso_tx_contador_bits.sv
// Bit counter: up-counter with synchronous clear, enable and terminal-count flag.
// Holds at MAX instead of wrapping, so tc stays valid until the next clear.
module contador_bits #(
    parameter int CNT_W = 2,
    parameter int MAX   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/registrador_piso_tx.sv
// Parallel-in/serial-out transmitter: MSB-first serial line with optional even parity.
//
// state  | meaning
// IDLE   | line idle, load_ready high, waiting for a handshake
// SHIFT  | data bits leave MSB first, one per clock
// PARITY | stored even-parity bit on the line
// DONE   | one-cycle done pulse, line back to idle level
module registrador_piso_tx
    import registrador_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             Dout_serie,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    tx_state_t        state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             parity_q;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             dout_nxt, frame_nxt, busy_nxt, done_nxt, ready_nxt;

    assign accept = (state == IDLE) && load_valid && load_ready;

    contador_bits #(
        .CNT_W (CNT_W),
        .MAX   (WIDTH - 1)
    ) u_contador_bits (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (state == SHIFT),
        .count (cnt),
        .tc    (cnt_tc)
    );

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_comb begin
        state_nxt = state;
        dout_nxt  = LINE_IDLE;
        frame_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                dout_nxt  = shreg[WIDTH-1];
                frame_nxt = 1'b1;
                busy_nxt  = 1'b1;
                if (cnt_tc) state_nxt = PARITY_EN ? PARITY : DONE;
            end
            PARITY: begin
                dout_nxt  = parity_q;
                frame_nxt = 1'b1;
                busy_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            Dout_serie <= LINE_IDLE;
            frame      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            Dout_serie <= dout_nxt;
            frame      <= frame_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            load_ready <= ready_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            parity_q <= 1'b0;
        end else if (accept) begin
            shreg    <= Din;
            parity_q <= ^Din;
        end else if (state == SHIFT) begin
            shreg    <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_registrador_piso_tx.sv
// Bench for registrador_piso_tx: three configurations driven in parallel, checked per cycle.
module tb_registrador_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       load_valid;

    logic ready4, dout4, frame4, busy4, done4;
    logic ready4p, dout4p, frame4p, busy4p, done4p;
    logic ready8, dout8, frame8, busy8, done8;

    logic [3:0] rx4;
    logic [4:0] tr4  [1:12];
    logic [4:0] tr4p [1:12];
    logic [4:0] tr8  [1:12];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    registrador_piso_tx #(.WIDTH(4), .PARITY_EN(1'b0)) u4 (
        .clk(clk), .reset(reset), .Din(din[3:0]), .load_valid(load_valid),
        .load_ready(ready4), .Dout_serie(dout4), .frame(frame4), .busy(busy4), .done(done4)
    );
    registrador_piso_tx #(.WIDTH(4), .PARITY_EN(1'b1)) u4p (
        .clk(clk), .reset(reset), .Din(din[3:0]), .load_valid(load_valid),
        .load_ready(ready4p), .Dout_serie(dout4p), .frame(frame4p), .busy(busy4p), .done(done4p)
    );
    registrador_piso_tx #(.WIDTH(8), .PARITY_EN(1'b0)) u8 (
        .clk(clk), .reset(reset), .Din(din), .load_valid(load_valid),
        .load_ready(ready8), .Dout_serie(dout8), .frame(frame8), .busy(busy8), .done(done8)
    );

    // Serial-in receiving register paired with the 4-bit transmitter.
    always @(posedge clk or posedge reset) begin
        if (reset) rx4 <= 4'h0;
        else if (frame4) rx4 <= {rx4[2:0], dout4};
    end

    // Expected {dout, frame, busy, done, ready} k cycles after the acceptance edge.
    function automatic logic [4:0] exp_vec(input int w, input bit pe, input logic [7:0] word, input int k);
        int nb;
        logic b;
        nb = w + (pe ? 1 : 0);
        if (k >= 1 && k <= w) begin
            b = ((int'(word) >> (w - k)) & 1) != 0;
            return {b, 4'b1100};
        end
        if (pe && k == w + 1) begin
            b = ($countones(int'(word) & ((1 << w) - 1)) % 2) != 0;
            return {b, 4'b1100};
        end
        if (k == nb + 1) return 5'b00110;
        return 5'b00001;
    endfunction

    task automatic do_accept(input logic [7:0] word);
        int i;
        i = 0;
        @(negedge clk);
        while (!(ready4 && ready4p && ready8) && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!(ready4 && ready4p && ready8)) begin
            n_total++;
            $display("FAIL accept_timeout ready=%b%b%b required=111", ready4, ready4p, ready8);
        end
        din = word;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int drop);
        if (drop == 0) load_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            tr4[k]  = {dout4, frame4, busy4, done4, ready4};
            tr4p[k] = {dout4p, frame4p, busy4p, done4p, ready4p};
            tr8[k]  = {dout8, frame8, busy8, done8, ready8};
            if (k == drop) load_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_valid = 1'b0;
        din = 8'h00;
        #2;
        n_total++;
        if ({dout4, frame4, busy4, done4, ready4, dout8, frame8, busy8, done8, ready8} !== 10'b0000100001)
            $display("FAIL reset_state got=%b%b%b%b%b required=00001", dout4, frame4, busy4, done4, ready4);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({dout4p, frame4p, busy4p, done4p, ready4p} !== 5'b00001)
            $display("FAIL idle_after_reset got=%b%b%b%b%b required=00001", dout4p, frame4p, busy4p, done4p, ready4p);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [4:0] e;
        do_accept(8'h0B);
        record(0);
        for (int k = 1; k <= 12; k++) begin
            e = exp_vec(4, 1'b0, 8'h0B, k);
            n_total++;
            if (tr4[k] !== e) $display("FAIL basic_w4 k=%0d got=%b required=%b", k, tr4[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_parity;
        logic [4:0] e;
        logic [7:0] words [2];
        words[0] = 8'h0B;
        words[1] = 8'h06;
        for (int j = 0; j < 2; j++) begin
            do_accept(words[j]);
            record(0);
            for (int k = 1; k <= 12; k++) begin
                e = exp_vec(4, 1'b1, words[j], k);
                n_total++;
                if (tr4p[k] !== e) $display("FAIL parity_w4 word=%h k=%0d got=%b required=%b", words[j], k, tr4p[k], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_loopback;
        for (int v = 0; v < 16; v++) begin
            do_accept(8'(v));
            record(0);
            n_total++;
            if (rx4 !== 4'(v)) $display("FAIL loopback got=%h required=%h", rx4, 4'(v));
            else n_pass++;
        end
    endtask

    task automatic test_ignored_load;
        logic [4:0] e;
        do_accept(8'h01);
        din = 8'h0F;
        record(4);
        for (int k = 1; k <= 12; k++) begin
            e = exp_vec(4, 1'b0, 8'h01, k);
            n_total++;
            if (tr4[k] !== e) $display("FAIL ignored_load k=%0d got=%b required=%b", k, tr4[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [4:0] e;
        do_accept(8'h0D);
        load_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (dout4 !== 1'b1) $display("FAIL reset_mid_bit k=%0d got=%b required=1", k, dout4);
            else n_pass++;
        end
        reset = 1'b1;
        #1;
        n_total++;
        if ({dout4, frame4, busy4, done4, ready4} !== 5'b00001)
            $display("FAIL reset_mid_abort got=%b%b%b%b%b required=00001", dout4, frame4, busy4, done4, ready4);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            n_total++;
            if ({dout4, frame4, busy4, done4, ready4} !== 5'b00001)
                $display("FAIL reset_mid_after k=%0d got=%b%b%b%b%b required=00001", k, dout4, frame4, busy4, done4, ready4);
            else n_pass++;
        end
        do_accept(8'h05);
        record(0);
        for (int k = 1; k <= 12; k++) begin
            e = exp_vec(4, 1'b0, 8'h05, k);
            n_total++;
            if (tr4[k] !== e) $display("FAIL reset_mid_next k=%0d got=%b required=%b", k, tr4[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_wide;
        logic [4:0] e;
        do_accept(8'hA5);
        record(0);
        for (int k = 1; k <= 12; k++) begin
            e = exp_vec(8, 1'b0, 8'hA5, k);
            n_total++;
            if (tr8[k] !== e) $display("FAIL wide_w8 k=%0d got=%b required=%b", k, tr8[k], e);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [4:0] e4, e4p, e8;
        logic [7:0] w;
        for (int r = 0; r < 8; r++) begin
            w = 8'($urandom);
            do_accept(w);
            record(0);
            for (int k = 1; k <= 12; k++) begin
                e4  = exp_vec(4, 1'b0, w, k);
                e4p = exp_vec(4, 1'b1, w, k);
                e8  = exp_vec(8, 1'b0, w, k);
                n_total++;
                if (tr4[k] !== e4) $display("FAIL rand_w4 word=%h k=%0d got=%b required=%b", w, k, tr4[k], e4);
                else n_pass++;
                n_total++;
                if (tr4p[k] !== e4p) $display("FAIL rand_w4p word=%h k=%0d got=%b required=%b", w, k, tr4p[k], e4p);
                else n_pass++;
                n_total++;
                if (tr8[k] !== e8) $display("FAIL rand_w8 word=%h k=%0d got=%b required=%b", w, k, tr8[k], e8);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_loopback;
        test_ignored_load;
        test_reset_mid;
        test_wide;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
